// File: rtl/id_scoreboard.sv
// id_scoreboard: RAW interlock between decode and EXE.
// Keeps a per-register count of writes in flight and holds decode while a source is pending.
module id_scoreboard #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned NREG  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [4:0]         id_src1,
    input  logic [4:0]         id_src2,
    input  logic               id_src1_used,
    input  logic               id_src2_used,
    input  logic               id_wen,
    input  logic [4:0]         id_waddr,
    input  logic               exe_ready,
    input  logic               wb_valid,
    input  logic [4:0]         wb_waddr,
    output logic               id_stall,
    output logic               issue_fire,
    output logic               id_ready,
    output logic               pending_any,
    output logic [CNT_W+4:0]   pending_cnt
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned SUM_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt [NREG];
    logic [CNT_W-1:0] w_cnt_nxt [NREG];
    logic [SUM_W-1:0] w_sum_nxt;
    logic [SUM_W-1:0] r_pending_cnt;
    logic             r_pending_any;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_hazw;
    logic             w_stall;
    logic             w_fire;

    // Hazard detection against the current (pre-writeback) counters; no bypass.
    always_comb begin
        w_haz1  = id_src1_used && (id_src1  != '0) && (r_cnt[id_src1]  != '0);
        w_haz2  = id_src2_used && (id_src2  != '0) && (r_cnt[id_src2]  != '0);
        w_hazw  = id_wen       && (id_waddr != '0) && (r_cnt[id_waddr] == CNT_MAX);
        w_stall = id_valid && (w_haz1 || w_haz2 || w_hazw);
        w_fire  = id_valid && exe_ready && !w_stall && !flush;
    end

    assign id_stall    = w_stall;
    assign issue_fire  = w_fire;
    assign id_ready    = exe_ready && !w_stall;
    assign pending_any = r_pending_any;
    assign pending_cnt = r_pending_cnt;

    // Next-state counters and their total; r0 is pinned to zero, flush clears everything.
    always_comb begin
        w_sum_nxt = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            if (flush || (r == 0)) begin
                w_cnt_nxt[r] = '0;
            end else if ((w_fire && id_wen && (id_waddr == IDX_W'(r))) &&
                         !(wb_valid && (wb_waddr == IDX_W'(r)) && (r_cnt[r] != '0))) begin
                w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
            end else if (!(w_fire && id_wen && (id_waddr == IDX_W'(r))) &&
                         (wb_valid && (wb_waddr == IDX_W'(r)) && (r_cnt[r] != '0))) begin
                w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
            end
            w_sum_nxt = w_sum_nxt + SUM_W'(w_cnt_nxt[r]);
        end
    end

    // Counter and summary registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_pending_cnt <= '0;
            r_pending_any <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_pending_cnt <= w_sum_nxt;
            r_pending_any <= (w_sum_nxt != '0);
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus random traffic against a count model.
module tb_id_scoreboard;

    localparam int CNT_W = 2;
    localparam int NREG  = 32;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset, flush, id_valid, id_src1_used, id_src2_used, id_wen;
    logic       exe_ready, wb_valid;
    logic [4:0] id_src1, id_src2, id_waddr, wb_waddr;
    logic       id_stall, issue_fire, id_ready, pending_any;
    logic [CNT_W+4:0] pending_cnt;

    int vectors = 0;
    int errors  = 0;
    int model [NREG];
    logic s_stall, s_fire, s_ready;

    id_scoreboard #(.CNT_W(CNT_W), .NREG(NREG)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_wen(id_wen), .id_waddr(id_waddr), .exe_ready(exe_ready),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr),
        .id_stall(id_stall), .issue_fire(issue_fire), .id_ready(id_ready),
        .pending_any(pending_any), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare against the model at negedge, then advance the model.
    task automatic cyc(input logic v, input int s1, input logic u1, input int s2, input logic u2,
                       input logic wen, input int wa, input logic exr,
                       input logic wbv, input int wba, input logic fl, input logic rst);
        logic e_stall, e_fire, e_ready;
        int   sum;
        reset = rst; flush = fl; id_valid = v;
        id_src1 = 5'(s1); id_src1_used = u1; id_src2 = 5'(s2); id_src2_used = u2;
        id_wen = wen; id_waddr = 5'(wa); exe_ready = exr;
        wb_valid = wbv; wb_waddr = 5'(wba);
        @(negedge clk);
        e_stall = v && ((u1 && s1 != 0 && model[s1] > 0) ||
                        (u2 && s2 != 0 && model[s2] > 0) ||
                        (wen && wa != 0 && model[wa] == MAXC));
        e_fire  = v && exr && !e_stall && !fl;
        e_ready = exr && !e_stall;
        sum = 0;
        foreach (model[i]) sum += model[i];
        chk("id_stall",    32'(id_stall),    32'(e_stall));
        chk("issue_fire",  32'(issue_fire),  32'(e_fire));
        chk("id_ready",    32'(id_ready),    32'(e_ready));
        chk("pending_cnt", 32'(pending_cnt), 32'(sum));
        chk("pending_any", 32'(pending_any), 32'(sum != 0));
        s_stall = id_stall; s_fire = issue_fire; s_ready = id_ready;
        if (rst || fl) begin
            foreach (model[i]) model[i] = 0;
        end else begin
            if (wbv && wba != 0 && model[wba] > 0) model[wba]--;
            if (e_fire && wen && wa != 0) model[wa]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wbv, input int wba);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, wbv, wba, 0, 0);
    endtask

    task automatic issue_w(input int wa);
        cyc(1, 0, 0, 0, 0, 1, wa, 1, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (model[i]) model[i] = 0;
        reset = 1; flush = 0; id_valid = 0; id_src1 = 0; id_src2 = 0;
        id_src1_used = 0; id_src2_used = 0; id_wen = 0; id_waddr = 0;
        exe_ready = 1; wb_valid = 0; wb_waddr = 0;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("rst_pending_cnt", 32'(pending_cnt), 32'd0);
        chk("rst_pending_any", 32'(pending_any), 32'd0);

        // Back-to-back RAW on r5
        issue_w(5);
        chk("b2b_cnt_a", 32'(pending_cnt), 32'd1);
        cyc(1, 5, 1, 0, 0, 1, 6, 1, 0, 0, 0, 0);
        chk("b2b_stall", 32'(s_stall), 32'd1);
        chk("b2b_nofire", 32'(s_fire), 32'd0);
        cyc(1, 5, 1, 0, 0, 1, 6, 1, 1, 5, 0, 0);
        chk("b2b_stall_wbcyc", 32'(s_stall), 32'd1);
        chk("b2b_cnt_b", 32'(pending_cnt), 32'd0);
        cyc(1, 5, 1, 0, 0, 1, 6, 1, 0, 0, 0, 0);
        chk("b2b_fire", 32'(s_fire), 32'd1);
        chk("b2b_cnt_c", 32'(pending_cnt), 32'd1);

        // Unused source on a pending register
        cyc(1, 0, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("unused_fire", 32'(s_fire), 32'd1);

        // r0 never tracked
        issue_w(0);
        cyc(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_nostall", 32'(s_stall), 32'd0);
        idle(1, 0);
        chk("r0_cnt", 32'(pending_cnt), 32'd1);
        idle(1, 6);
        chk("r0_clear", 32'(pending_cnt), 32'd0);

        // Saturation on r7
        issue_w(7); issue_w(7); issue_w(7);
        chk("sat_cnt3", 32'(pending_cnt), 32'd3);
        cyc(1, 0, 0, 0, 0, 1, 7, 1, 1, 7, 0, 0);
        chk("sat_stall", 32'(s_stall), 32'd1);
        chk("sat_ready", 32'(s_ready), 32'd0);
        chk("sat_cnt2", 32'(pending_cnt), 32'd2);
        issue_w(7);
        chk("sat_release", 32'(s_fire), 32'd1);
        idle(1, 7); idle(1, 7); idle(1, 7);
        chk("sat_drain", 32'(pending_cnt), 32'd0);

        // Simultaneous issue + wb on r9, and underflow on r12
        issue_w(9);
        cyc(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0, 0);
        chk("simul_cnt", 32'(pending_cnt), 32'd1);
        idle(1, 12);
        chk("underflow_cnt", 32'(pending_cnt), 32'd1);
        idle(1, 9);

        // Flush mid-stall
        issue_w(3); issue_w(3); issue_w(4);
        chk("fl_pre", 32'(pending_cnt), 32'd3);
        cyc(1, 3, 1, 0, 0, 0, 0, 1, 1, 4, 1, 0);
        chk("fl_nofire", 32'(s_fire), 32'd0);
        chk("fl_cnt", 32'(pending_cnt), 32'd0);
        chk("fl_any", 32'(pending_any), 32'd0);
        cyc(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("fl_nostall", 32'(s_stall), 32'd0);

        // Reset mid-stall
        issue_w(3);
        cyc(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        chk("rs_stall", 32'(s_stall), 32'd1);
        chk("rs_cnt", 32'(pending_cnt), 32'd0);
        cyc(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("rs_nostall", 32'(s_stall), 32'd0);

        // Random traffic on a narrow register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Register-dependency scheduler between the decode stage and the EXE stage.
- Tracks every architectural register with a write outstanding in EXE/MEM/WB.
- Holds back the decode-to-EXE handshake while a source operand of the decoded instruction is still pending (RAW interlock; no forwarding network).
- Releases pending state as writebacks retire. Clears all tracking on pipeline flush.

Parameters:
- CNT_W, 2, width of each per-register pending counter; max in-flight writers per register = 2^CNT_W - 1.
- NREG, 32, number of architectural registers; register 0 is never tracked.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; clears all pending state
- id_valid  in  1  decode stage holds a valid decoded instruction
- id_src1  in  5  source register index 1 (rj)
- id_src2  in  5  source register index 2 (rk, or rd for stores)
- id_src1_used  in  1  instruction reads id_src1
- id_src2_used  in  1  instruction reads id_src2
- id_wen  in  1  instruction writes a register
- id_waddr  in  5  destination register index
- exe_ready  in  1  EXE stage can accept (downstream right_ready)
- wb_valid  in  1  a register write retires this cycle
- wb_waddr  in  5  index of the retiring write
- id_stall  out  1  hazard present; decode must hold its instruction
- issue_fire  out  1  instruction moves to EXE this cycle
- id_ready  out  1  decode may accept a new instruction (left_ready replacement)
- pending_any  out  1  at least one register has a write outstanding
- pending_cnt  out  CNT_W+5  total outstanding writes, summed over all registers

Behaviour:
- State is cnt[r], CNT_W bits, for r = 1..NREG-1. cnt[0] is constant 0.
- Reset: all cnt = 0; pending_any = 0; pending_cnt = 0. id_stall, issue_fire and id_ready follow from combinational inputs: with id_valid = 0, id_stall = 0, issue_fire = 0, id_ready = exe_ready.
- Hazard terms, all combinational, no cycle latency:
  - haz1 = id_src1_used & (id_src1 != 0) & (cnt[id_src1] != 0)
  - haz2 = id_src2_used & (id_src2 != 0) & (cnt[id_src2] != 0)
  - hazw = id_wen & (id_waddr != 0) & (cnt[id_waddr] == max). This is a saturation stall.
- id_stall = id_valid & (haz1 | haz2 | hazw).
- issue_fire = id_valid & exe_ready & ~id_stall & ~flush.
- id_ready = exe_ready & ~id_stall.
- A writeback in the current cycle does NOT clear a hazard in the same cycle; the stall releases the cycle after cnt drops to 0. There is no bypass.
- Counter update at posedge, per register r, when not reset and not flush:
  - inc = issue_fire & id_wen & (id_waddr == r) & (r != 0)
  - dec = wb_valid & (wb_waddr == r) & (r != 0) & (cnt[r] != 0)
  - inc & ~dec: cnt + 1. dec & ~inc: cnt - 1. Both: unchanged. Neither: unchanged.
- Underflow: a wb_valid to a register with cnt = 0 is ignored. The counter stays 0 and never wraps.
- Overflow: cannot occur, because hazw blocks issue at max.
- Writes to r0 (issue or wb) are ignored.
- Flush, including when asserted mid-stall or alongside issue or wb: next cycle all cnt = 0, pending_cnt = 0. In the flush cycle itself issue_fire = 0.
- Reset has priority over flush.
- pending_any and pending_cnt are registered: they are recomputed from the next-state counters and update on the same edge as cnt.
- Writeback order between different registers is unconstrained. Same-register writebacks retire in program order; only the count matters.

Test Plan:
- Back-to-back dependency. Issue wen=1 waddr=5, then decode src1=5 used.
  - Expect id_stall=1 and issue_fire=0 until the cycle after wb_valid waddr=5.
  - Then issue_fire=1 with exe_ready=1. pending_cnt goes 1 -> 0 -> 1.
- Unused source. src2=5 with id_src2_used=0 while cnt[5]=1 → id_stall=0, issue_fire=1.
- r0 handling. Issue wen=1 waddr=0, then decode src1=0 used → no stall; pending_cnt stays 0. wb_valid waddr=0 also causes no change.
- Saturation, CNT_W=2.
  - Issue three writers to r7, no wb → cnt[7]=3. A fourth writer to r7 → id_stall=1, id_ready=0.
  - One wb to r7 → next cycle cnt[7]=2 and the stall releases.
- Simultaneous events.
  - Issue writer to r9 in the same cycle as wb to r9, with cnt[9]=1 → cnt[9] stays 1.
  - wb to r12 with cnt[12]=0 → stays 0, pending_cnt unchanged.
- Flush.
  - r3=2 and r4=1 pending with decode stalled on r3. Assert flush alongside id_valid and exe_ready → issue_fire=0 that cycle.
  - Next cycle all cnt=0, pending_any=0, id_stall=0.
  - Reset asserted mid-stall → same cleared state.
